// File: rtl/mem_access_ctrl.sv
// Purpose: CPU-side initiator for the unified memory; sequences one instruction fetch, then one load, store or no-op access on port 1.
// Latency: instr_valid arrives 3 cycles after start; done arrives 1, 2 or 3 cycles after op_valid for none, store or load.
// Backpressure: none; start is taken only in IDLE and op_valid only in OPWAIT, and nothing is queued.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  op_valid,
    input  logic [1:0]            op_kind,
    input  logic [ADDR_WIDTH-1:0] op_addr,
    input  logic [DATA_WIDTH-1:0] op_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  done,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           instr_count,
    output logic [ADDR_WIDTH-1:0] mem_pc,
    output logic                  mem_fetch,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    output logic [DATA_WIDTH-1:0] mem_din1,
    output logic                  mem_we1,
    input  logic [DATA_WIDTH-1:0] mem_dout1,
    input  logic [DATA_WIDTH-1:0] mem_instr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FCAP,
        S_OPWAIT,
        S_LDADDR,
        S_LDDATA,
        S_STORE,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   pc_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    op_take;

    // The data operation is accepted only while waiting for it.
    assign op_take = (state == S_OPWAIT) && op_valid;

    // Memory-side outputs come from state and registers only, so core inputs never reach the memory combinationally.
    assign mem_pc    = pc_reg;
    assign mem_addr1 = addr_reg;
    assign mem_din1  = data_reg;
    assign mem_fetch = (state == S_FETCH);
    assign mem_we1   = (state == S_STORE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: fixed walk through fetch, branch on the operation kind in OPWAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_FCAP;
            S_FCAP:   state_nxt = S_OPWAIT;
            S_OPWAIT: begin
                if (op_valid) begin
                    case (op_kind)
                        2'b01:   state_nxt = S_LDADDR;
                        2'b10:   state_nxt = S_STORE;
                        default: state_nxt = S_DONE;
                    endcase
                end
            end
            S_LDADDR: state_nxt = S_LDDATA;
            S_LDDATA: state_nxt = S_DONE;
            S_STORE:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: latched addresses/data, captured memory results, sticky error and sequence counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg      <= '0;
            addr_reg    <= '0;
            data_reg    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            load_data   <= '0;
            err         <= 1'b0;
            instr_count <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                pc_reg <= pc_in;
            end
            if (op_take) begin
                addr_reg <= op_addr;
                data_reg <= op_data;
                if (op_kind == 2'b11) begin
                    err <= 1'b1;
                end
            end
            if (state == S_FCAP) begin
                instr <= mem_instr;
            end
            // Registered so the pulse lands on the first OPWAIT cycle only.
            instr_valid <= (state == S_FCAP);
            if (state == S_LDDATA) begin
                load_data <= mem_dout1;
            end
            if (state == S_DONE) begin
                instr_count <= instr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose: directed self-checking bench for mem_access_ctrl with a small dual-port memory model.
// Latency: checks fetch, instr_valid and done timing cycle by cycle against hand-derived values.
// Backpressure: exercises ignored start/op_valid while busy and reset during a store.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pc_in;
    logic        op_valid;
    logic [1:0]  op_kind;
    logic [15:0] op_addr;
    logic [15:0] op_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] load_data;
    logic        done;
    logic        busy;
    logic        err;
    logic [15:0] instr_count;
    logic [15:0] mem_pc;
    logic        mem_fetch;
    logic [15:0] mem_addr1;
    logic [15:0] mem_din1;
    logic        mem_we1;
    logic [15:0] mem_dout1;
    logic [15:0] mem_instr;

    logic [15:0] ram [256];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cnt = 16'd0;

    mem_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc_in       (pc_in),
        .op_valid    (op_valid),
        .op_kind     (op_kind),
        .op_addr     (op_addr),
        .op_data     (op_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .load_data   (load_data),
        .done        (done),
        .busy        (busy),
        .err         (err),
        .instr_count (instr_count),
        .mem_pc      (mem_pc),
        .mem_fetch   (mem_fetch),
        .mem_addr1   (mem_addr1),
        .mem_din1    (mem_din1),
        .mem_we1     (mem_we1),
        .mem_dout1   (mem_dout1),
        .mem_instr   (mem_instr)
    );

    always #5 clk = ~clk;

    // Memory model: registered port-1 read, write on edge, instruction latched on the fetchPhase edge.
    always @(posedge clk) begin
        mem_dout1 <= ram[mem_addr1[7:0]];
        if (mem_we1) ram[mem_addr1[7:0]] <= mem_din1;
        if (mem_fetch) mem_instr <= ram[mem_pc[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full sequence; lat is the expected op_valid-to-done distance, disturb pulses start/op_valid during FETCH.
    task automatic run_seq(input logic [15:0] pc, input logic [15:0] exp_instr,
                           input logic [1:0] kind, input logic [15:0] addr,
                           input logic [15:0] data, input int lat, input int exp_we,
                           input bit disturb);
        int cyc;
        int we_cnt;
        start = 1'b1;
        pc_in = pc;
        tick();                                   // cycle 1: FETCH
        start    = disturb;
        op_valid = disturb;
        op_kind  = 2'b01;
        op_addr  = 16'h00AA;
        chk("fetch_hi", mem_fetch, 1);
        chk("fetch_pc", mem_pc, pc);
        chk("busy_fetch", busy, 1);
        tick();                                   // cycle 2: FCAP
        start    = 1'b0;
        op_valid = 1'b0;
        chk("fetch_lo", mem_fetch, 0);
        chk("ivld_early", instr_valid, 0);
        tick();                                   // cycle 3: OPWAIT
        chk("ivld", instr_valid, 1);
        chk("instr", instr, exp_instr);
        op_valid = 1'b1;
        op_kind  = kind;
        op_addr  = addr;
        op_data  = data;
        tick();
        op_valid = 1'b0;
        chk("ivld_pulse", instr_valid, 0);
        cyc    = 1;
        we_cnt = 0;
        while (!done && cyc < 10) begin
            chk("busy_seq", busy, 1);
            if (mem_we1) begin
                we_cnt++;
                chk("we_addr", mem_addr1, addr);
                chk("we_din", mem_din1, data);
            end
            tick();
            cyc++;
        end
        chk("done_lat", cyc, lat);
        chk("we_cycles", we_cnt, exp_we);
        chk("cnt_in_done", instr_count, exp_cnt);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("done_pulse", done, 0);
        chk("idle", busy, 0);
        chk("cnt", instr_count, exp_cnt);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[5]   = 16'h1234;
        ram[8]   = 16'h4321;
        mem_dout1 = 16'h0;
        mem_instr = 16'h0;
        reset    = 1'b1;
        start    = 1'b0;
        pc_in    = 16'h0;
        op_valid = 1'b0;
        op_kind  = 2'b00;
        op_addr  = 16'h0;
        op_data  = 16'h0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_fetch", mem_fetch, 0);
        chk("rst_we", mem_we1, 0);
        chk("rst_instr", instr, 0);

        // Store 0xBEEF to 0x20: written in one cycle, done two cycles after op_valid.
        run_seq(16'h0005, 16'h1234, 2'b10, 16'h0020, 16'hBEEF, 2, 1, 1'b0);
        chk("ram_store", ram[8'h20], 16'hBEEF);
        // Load back from 0x20: done three cycles after op_valid, no write strobe.
        run_seq(16'h0005, 16'h1234, 2'b01, 16'h0020, 16'h0000, 3, 0, 1'b0);
        chk("load_data", load_data, 16'hBEEF);
        chk("err_clean", err, 0);
        // Reserved kind: sticky error, done one cycle after op_valid.
        run_seq(16'h0008, 16'h4321, 2'b11, 16'h0030, 16'h1111, 1, 0, 1'b0);
        chk("err_set", err, 1);
        // Clean no-op sequence with start/op_valid pulsed during FETCH: timing unchanged, err held.
        run_seq(16'h0005, 16'h1234, 2'b00, 16'h0040, 16'h2222, 1, 0, 1'b1);
        chk("err_sticky", err, 1);
        chk("load_hold", load_data, 16'hBEEF);
        chk("ram_untouched", ram[8'h30], 16'h0000);

        // Reset in the middle of STORE aborts the write.
        start = 1'b1;
        pc_in = 16'h0005;
        tick();
        start = 1'b0;
        tick();
        tick();
        op_valid = 1'b1;
        op_kind  = 2'b10;
        op_addr  = 16'h0030;
        op_data  = 16'h5555;
        tick();
        op_valid = 1'b0;
        chk("store_we", mem_we1, 1);
        reset = 1'b1;
        #1;
        chk("abort_we", mem_we1, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 0);
        chk("abort_cnt", instr_count, 0);
        chk("abort_load", load_data, 0);
        chk("abort_addr", mem_addr1, 0);
        tick();
        chk("abort_ram", ram[8'h30], 16'h0000);
        reset = 1'b0;
        tick();

        // Counter wrap from 0xFFFF.
        force dut.instr_count = 16'hFFFF;
        #1;
        release dut.instr_count;
        exp_cnt = 16'hFFFF;
        run_seq(16'h0005, 16'h1234, 2'b00, 16'h0000, 16'h0000, 1, 0, 1'b0);
        chk("cnt_wrap", instr_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the dual-port unified memory. It sequences instruction fetch through the memory's fetch port, then one data access (load, store or none) through port 1.
- It absorbs the memory's timing: one-cycle registered read address, fetch gated by fetchPhase, write on clock edge.
- It gives the core a simple start/op/done handshake.
- Sits between the control FSM/datapath and the memory; port 2 is not used by this block.

Parameters:
- DATA_WIDTH, 16, width of memory words and data buses
- ADDR_WIDTH, 16, width of memory addresses and PC

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  core request to fetch the instruction at pc_in
- pc_in  in  ADDR_WIDTH  program counter, sampled with start
- op_valid  in  1  core presents the data operation for the fetched instruction
- op_kind  in  2  00 none, 01 load, 10 store, 11 reserved
- op_addr  in  ADDR_WIDTH  data address, sampled with op_valid
- op_data  in  DATA_WIDTH  store data, sampled with op_valid
- instr  out  DATA_WIDTH  captured instruction; held until the next fetch capture
- instr_valid  out  1  one-cycle pulse when instr is updated
- load_data  out  DATA_WIDTH  captured load result; held until the next load
- done  out  1  one-cycle pulse when the access sequence ends
- busy  out  1  high in every state except IDLE
- err  out  1  sticky; set when op_kind=11 is accepted
- instr_count  out  16  number of completed sequences, wraps modulo 2^16
- mem_pc  out  ADDR_WIDTH  to memory ProgramCounter
- mem_fetch  out  1  to memory fetchPhase
- mem_addr1  out  ADDR_WIDTH  to memory addr1
- mem_din1  out  DATA_WIDTH  to memory dataIn1
- mem_we1  out  1  to memory we1
- mem_dout1  in  DATA_WIDTH  from memory dataOut1; valid the cycle after addr1 was presented
- mem_instr  in  DATA_WIDTH  from memory instruction; valid the cycle after the fetchPhase edge

Behaviour:
- Reset values: state IDLE; every output and internal register 0; mem_we1=0 and mem_fetch=0 immediately on reset assertion. A store in flight is aborted.
- Memory-side outputs decode from registered state and registers only; no combinational path from core inputs.
- mem_pc=pc_reg at all times. mem_addr1=addr_reg and mem_din1=data_reg at all times.
- mem_fetch=1 only in FETCH. mem_we1=1 only in STORE.
- State transitions:
  - IDLE: start=1 -> latch pc_reg<=pc_in, go FETCH. Otherwise stay.
  - FETCH: one cycle; the memory latches the instruction at the end of it -> FCAP.
  - FCAP: instr<=mem_instr at the edge -> OPWAIT.
  - OPWAIT: instr_valid=1 on the first cycle only. On op_valid=1, latch addr_reg<=op_addr and data_reg<=op_data, then branch on op_kind:
    - 01 -> LDADDR
    - 10 -> STORE
    - 00 -> DONE
    - 11 -> set err, go DONE
  - LDADDR: one cycle presenting the address -> LDDATA.
  - LDDATA: load_data<=mem_dout1 at the edge -> DONE.
  - STORE: mem_we1=1 for exactly one cycle -> DONE.
  - DONE: done=1; instr_count<=instr_count+1 -> IDLE.
- Latencies, counted from the cycle start is sampled:
  - instr_valid in cycle 3.
  - From op_valid sampled in cycle n: none -> done at n+1; store -> write edge at end of n+1, done at n+2; load -> done at n+3 with load_data valid that cycle.
- start is ignored outside IDLE; no queuing, no error.
- op_valid is ignored outside OPWAIT.
- op_valid in the same cycle as start (IDLE) is ignored.
- load_data, instr, err hold their values across sequences; err clears only on reset.
- instr_count wraps 0xFFFF -> 0x0000.
- The minimum back-to-back period is 5 cycles (start -> none -> done -> IDLE); start may be asserted in the cycle the FSM is in IDLE after DONE.

Test Plan:
- Memory model holds 0x1234 at address 0x0005. Reset, then start with pc_in=0x0005 -> mem_fetch high for one cycle, instr=0x1234, instr_valid pulse in cycle 3, busy=1 until DONE.
- After the fetch, op_valid with op_kind=10, op_addr=0x0020, op_data=0xBEEF -> mem_we1 high exactly one cycle with mem_addr1=0x0020 and mem_din1=0xBEEF; done two cycles after op_valid; the model shows ram[0x20]=0xBEEF.
- Next sequence: load from 0x0020 -> load_data=0xBEEF and done three cycles after op_valid; mem_we1 stays 0 throughout.
- op_kind=11 -> err=1, done one cycle after op_valid; err still 1 after a following clean sequence.
- start pulsed while busy, and op_valid pulsed in FETCH -> no change in sequence or timing; instr_count increments by exactly 1 per done.
- Reset asserted in the middle of STORE -> mem_we1 drops the same cycle, all outputs 0, state IDLE. After release, preset instr_count to 0xFFFF (force or 65535 sequences); the next done wraps it to 0x0000.
